// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word addresses to a one-cycle
// instruction memory and buffers one returned word in a skid entry when decode stalls.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 80
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fault
);

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    logic [31:0] fetch_pc;
    logic        resp_valid;
    logic [31:0] resp_pc;
    logic        hold_valid;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    logic [31:0] next_seq_pc;
    logic        redirect_bad;
    logic        issue;
    logic        capture;

    assign next_seq_pc  = (fetch_pc == LAST_PC) ? 32'd0 : fetch_pc + 32'd4;
    assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc > LAST_PC);

    // A new fetch goes out whenever the slot toward decode will be free after this edge.
    assign issue   = !fault && !redirect_valid &&
                     (hold_valid ? if_ready : (!resp_valid || if_ready));
    assign capture = !fault && !redirect_valid && !hold_valid && resp_valid && !if_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc   <= RESET_PC;
            resp_valid <= 1'b0;
            resp_pc    <= 32'd0;
            hold_valid <= 1'b0;
            hold_pc    <= 32'd0;
            hold_instr <= 32'd0;
            fault      <= 1'b0;
        end else if (!fault) begin
            if (redirect_valid) begin
                resp_valid <= 1'b0;
                hold_valid <= 1'b0;
                if (redirect_bad)
                    fault <= 1'b1;
                else
                    fetch_pc <= redirect_pc;
            end else begin
                if (issue) begin
                    resp_valid <= 1'b1;
                    resp_pc    <= fetch_pc;
                    fetch_pc   <= next_seq_pc;
                    hold_valid <= 1'b0;
                end
                // The memory word is only visible for one cycle, so park it before it is lost.
                if (capture) begin
                    hold_valid <= 1'b1;
                    hold_pc    <= resp_pc;
                    hold_instr <= imem_data;
                    resp_valid <= 1'b0;
                end
            end
        end
    end

    assign pc_addr = fetch_pc;

    always_comb begin
        if_valid = !fault && (resp_valid || hold_valid);
        if_instr = 32'd0;
        if_pc    = 32'd0;
        if (if_valid) begin
            if (hold_valid) begin
                if_instr = hold_instr;
                if_pc    = hold_pc;
            end else begin
                if_instr = imem_data;
                if_pc    = resp_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle instruction memory whose byte i holds i.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] pc_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fault;

    int checks;
    int passed;
    logic [31:0] exp_pc;

    fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_BYTES(80)) dut (
        .clk(clk),
        .reset(reset),
        .pc_addr(pc_addr),
        .imem_data(imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_instr(if_instr),
        .if_pc(if_pc),
        .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    always @(posedge clk) imem_data <= word_at(pc_addr);

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc_addr !== 32'd0) $display("[TB] FAIL reset_pc_addr got=%h exp=%h", pc_addr, 32'd0); else passed++;
            checks++; if (if_valid !== 1'b0) $display("[TB] FAIL reset_if_valid got=%b exp=0", if_valid); else passed++;
            checks++; if (if_instr !== 32'd0) $display("[TB] FAIL reset_if_instr got=%h exp=0", if_instr); else passed++;
            checks++; if (fault !== 1'b0) $display("[TB] FAIL reset_fault got=%b exp=0", fault); else passed++;
        end
        reset = 1'b1;
        tick();
        checks++; if (if_valid !== 1'b1) $display("[TB] FAIL first_valid got=%b exp=1", if_valid); else passed++;
        checks++; if (if_pc !== 32'd0) $display("[TB] FAIL first_pc got=%h exp=0", if_pc); else passed++;
        checks++; if (if_instr !== 32'h03020100) $display("[TB] FAIL first_instr got=%h exp=03020100", if_instr); else passed++;
    endtask

    task automatic test_stream();
        for (int i = 1; i < 22; i++) begin
            tick();
            exp_pc = 32'((i * 4) % 80);
            checks++; if (if_valid !== 1'b1) $display("[TB] FAIL stream_valid[%0d] got=%b exp=1", i, if_valid); else passed++;
            checks++; if (if_pc !== exp_pc) $display("[TB] FAIL stream_pc[%0d] got=%h exp=%h", i, if_pc, exp_pc); else passed++;
            checks++; if (if_instr !== word_at(exp_pc)) $display("[TB] FAIL stream_instr[%0d] got=%h exp=%h", i, if_instr, word_at(exp_pc)); else passed++;
        end
    endtask

    task automatic test_stall();
        tick();
        checks++; if (if_pc !== 32'd8) $display("[TB] FAIL stall_start_pc got=%h exp=8", if_pc); else passed++;
        if_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (if_pc !== 32'd8) $display("[TB] FAIL stall_pc[%0d] got=%h exp=8", i, if_pc); else passed++;
            checks++; if (if_instr !== 32'h0B0A0908) $display("[TB] FAIL stall_instr[%0d] got=%h exp=0B0A0908", i, if_instr); else passed++;
            checks++; if (if_valid !== 1'b1) $display("[TB] FAIL stall_valid[%0d] got=%b exp=1", i, if_valid); else passed++;
            checks++; if (pc_addr !== 32'd12) $display("[TB] FAIL stall_pc_addr[%0d] got=%h exp=c", i, pc_addr); else passed++;
            if (i < 3) tick();
        end
        if_ready = 1'b1;
        tick();
        checks++; if (if_pc !== 32'd12) $display("[TB] FAIL resume_pc got=%h exp=c", if_pc); else passed++;
        checks++; if (if_instr !== 32'h0F0E0D0C) $display("[TB] FAIL resume_instr got=%h exp=0F0E0D0C", if_instr); else passed++;
        checks++; if (if_valid !== 1'b1) $display("[TB] FAIL resume_valid got=%b exp=1", if_valid); else passed++;
        tick();
    endtask

    task automatic test_redirect();
        checks++; if (if_pc !== 32'd16) $display("[TB] FAIL redir_start_pc got=%h exp=10", if_pc); else passed++;
        redirect_valid = 1'b1; redirect_pc = 32'd40;
        tick();
        redirect_valid = 1'b0;
        checks++; if (if_valid !== 1'b0) $display("[TB] FAIL redir_bubble got=%b exp=0", if_valid); else passed++;
        checks++; if (pc_addr !== 32'd40) $display("[TB] FAIL redir_pc_addr got=%h exp=28", pc_addr); else passed++;
        tick();
        checks++; if (if_pc !== 32'd40) $display("[TB] FAIL redir_pc got=%h exp=28", if_pc); else passed++;
        checks++; if (if_instr !== 32'h2B2A2928) $display("[TB] FAIL redir_instr got=%h exp=2B2A2928", if_instr); else passed++;
        exp_pc = 32'd40;
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat;
        pat = 8'b1100_1101;
        for (int k = 0; k < 8; k++) begin
            if_ready = pat[k];
            checks++; if (if_valid !== 1'b1) $display("[TB] FAIL b2b_valid[%0d] got=%b exp=1", k, if_valid); else passed++;
            checks++; if (if_pc !== exp_pc) $display("[TB] FAIL b2b_pc[%0d] got=%h exp=%h", k, if_pc, exp_pc); else passed++;
            checks++; if (if_instr !== word_at(exp_pc)) $display("[TB] FAIL b2b_instr[%0d] got=%h exp=%h", k, if_instr, word_at(exp_pc)); else passed++;
            tick();
            if (pat[k]) exp_pc = (exp_pc == 32'd76) ? 32'd0 : exp_pc + 32'd4;
        end
        if_ready = 1'b1;
    endtask

    task automatic test_fault();
        checks++; if (if_pc !== 32'd60) $display("[TB] FAIL fault_start_pc got=%h exp=3c", if_pc); else passed++;
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fault !== 1'b1) $display("[TB] FAIL fault_set got=%b exp=1", fault); else passed++;
        checks++; if (if_valid !== 1'b0) $display("[TB] FAIL fault_valid got=%b exp=0", if_valid); else passed++;
        checks++; if (if_instr !== 32'd0) $display("[TB] FAIL fault_instr got=%h exp=0", if_instr); else passed++;
        checks++; if (pc_addr !== 32'd64) $display("[TB] FAIL fault_pc_addr got=%h exp=40", pc_addr); else passed++;
        redirect_valid = 1'b1; redirect_pc = 32'd8;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (fault !== 1'b1) $display("[TB] FAIL fault_sticky got=%b exp=1", fault); else passed++;
        checks++; if (pc_addr !== 32'd64) $display("[TB] FAIL fault_frozen got=%h exp=40", pc_addr); else passed++;
        checks++; if (if_valid !== 1'b0) $display("[TB] FAIL fault_no_issue got=%b exp=0", if_valid); else passed++;
        reset = 1'b0;
        tick();
        checks++; if (fault !== 1'b0) $display("[TB] FAIL fault_reset got=%b exp=0", fault); else passed++;
        checks++; if (pc_addr !== 32'd0) $display("[TB] FAIL fault_reset_pc got=%h exp=0", pc_addr); else passed++;
        reset = 1'b1;
        tick();
        checks++; if (if_pc !== 32'd0 || if_valid !== 1'b1) $display("[TB] FAIL fault_restart got=%h/%b exp=0/1", if_pc, if_valid); else passed++;
        checks++; if (if_instr !== 32'h03020100) $display("[TB] FAIL fault_restart_instr got=%h exp=03020100", if_instr); else passed++;
    endtask

    task automatic test_boundary_redirect();
        redirect_valid = 1'b1; redirect_pc = 32'd76;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fault !== 1'b0) $display("[TB] FAIL bnd_legal_fault got=%b exp=0", fault); else passed++;
        checks++; if (pc_addr !== 32'd76) $display("[TB] FAIL bnd_pc_addr got=%h exp=4c", pc_addr); else passed++;
        tick();
        checks++; if (if_pc !== 32'd76) $display("[TB] FAIL bnd_pc got=%h exp=4c", if_pc); else passed++;
        checks++; if (if_instr !== 32'h4F4E4D4C) $display("[TB] FAIL bnd_instr got=%h exp=4F4E4D4C", if_instr); else passed++;
        tick();
        checks++; if (if_pc !== 32'd0) $display("[TB] FAIL bnd_wrap_pc got=%h exp=0", if_pc); else passed++;
        redirect_valid = 1'b1; redirect_pc = 32'd80;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fault !== 1'b1) $display("[TB] FAIL bnd_range_fault got=%b exp=1", fault); else passed++;
        checks++; if (pc_addr !== 32'd4) $display("[TB] FAIL bnd_range_pc_addr got=%h exp=4", pc_addr); else passed++;
    endtask

    task automatic test_reset_during_stall();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (if_pc !== 32'd8) $display("[TB] FAIL rst_stall_pre_pc got=%h exp=8", if_pc); else passed++;
        if_ready = 1'b0;
        tick();
        checks++; if (if_pc !== 32'd8 || if_valid !== 1'b1) $display("[TB] FAIL rst_stall_held got=%h/%b exp=8/1", if_pc, if_valid); else passed++;
        reset = 1'b0;
        tick();
        checks++; if (if_valid !== 1'b0) $display("[TB] FAIL rst_stall_valid got=%b exp=0", if_valid); else passed++;
        checks++; if (pc_addr !== 32'd0) $display("[TB] FAIL rst_stall_pc_addr got=%h exp=0", pc_addr); else passed++;
        checks++; if (if_instr !== 32'd0) $display("[TB] FAIL rst_stall_instr got=%h exp=0", if_instr); else passed++;
        reset = 1'b1; if_ready = 1'b1;
        tick();
        checks++; if (if_pc !== 32'd0) $display("[TB] FAIL rst_stall_restart_pc got=%h exp=0", if_pc); else passed++;
        checks++; if (if_instr !== 32'h03020100) $display("[TB] FAIL rst_stall_restart_instr got=%h exp=03020100", if_instr); else passed++;
        tick();
        checks++; if (if_pc !== 32'd4) $display("[TB] FAIL rst_stall_next_pc got=%h exp=4", if_pc); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        exp_pc = 32'd0;
        reset = 1'b0;
        if_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_fault();
        test_boundary_redirect();
        test_reset_during_stall();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the byte address fetched first after reset.
REQ-002 Parameter IMEM_BYTES, default 80, is the instruction memory size in bytes (20 words).
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 pc_addr  output  32  byte address to instr_mem base_address; equals internal fetch_pc.
REQ-006 imem_data  input  32  instr_mem data_out; word for the address sampled at the previous edge.
REQ-007 redirect_valid  input  1  branch/jump request from a later stage.
REQ-008 redirect_pc  input  32  redirect target byte address.
REQ-009 if_valid  output  1  instruction presented to decode.
REQ-010 if_ready  input  1  decode accepts; transfer when if_valid && if_ready at an edge.
REQ-011 if_instr  output  32  presented instruction word.
REQ-012 if_pc  output  32  byte address of if_instr.
REQ-013 fault  output  1  sticky illegal-redirect flag.

Function
REQ-014 State SHALL be fetch_pc, resp_valid/resp_pc (word in flight from memory), hold_valid/hold_pc/hold_instr (skid entry), fault.
REQ-015 Modes: RUN (hold_valid=0), STALL (hold_valid=1), FAULT (fault=1); invariant: never resp_valid && hold_valid.
REQ-016 Outputs SHALL be: if_valid = !fault && (resp_valid || hold_valid); if_instr/if_pc = hold entry when hold_valid, else imem_data/resp_pc; both 0 when if_valid=0.
REQ-017 Issue SHALL occur at an edge when not FAULT, no redirect, and the presented word is accepted or none is presented: resp_valid<=1, resp_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
REQ-018 Sequential increment from IMEM_BYTES-4 SHALL wrap fetch_pc to 0.
REQ-019 If resp_valid && !if_ready: hold entry<=imem_data/resp_pc, hold_valid<=1, resp_valid<=0, fetch_pc unchanged.
REQ-020 In STALL, hold entry and fetch_pc SHALL hold while !if_ready; on if_ready, hold_valid<=0 and issue occurs at the same edge (no bubble).
REQ-021 Latency: word at address P SHALL appear on if_instr exactly one cycle after the edge at which pc_addr=P issued; steady-state throughput 1 word/cycle.
REQ-022 redirect_valid SHALL have priority over all handshake activity: resp_valid<=0, hold_valid<=0, fetch_pc<=redirect_pc; any transfer in that cycle is void.
REQ-023 Redirect with redirect_pc[1:0]!=0 or redirect_pc>IMEM_BYTES-4 SHALL set fault<=1, clear resp_valid/hold_valid, leave fetch_pc unchanged.
REQ-024 In FAULT no issue SHALL occur, redirects SHALL be ignored, pc_addr frozen; only reset exits.

Reset
REQ-025 While reset=0 at an edge: fetch_pc<=RESET_PC, resp_valid<=0, hold_valid<=0, fault<=0; thus pc_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, fault=0.
REQ-026 Reset SHALL override redirect, stall and fault at the same edge, discarding any held word.
REQ-027 First issue SHALL occur at the first edge with reset=1.

Verification (memory model: byte i holds value i)
REQ-028 Hold reset=0 3 cycles, release, if_ready=1 -> pc_addr=0 and if_valid=0 during reset; first cycle after release if_valid=1, if_pc=0, if_instr=32'h03020100.
REQ-029 if_ready=1 for 22 cycles -> if_pc 0,4,...,76 then 0, no gaps, each if_instr matches the model.
REQ-030 Drop if_ready at if_pc=8 for 3 cycles -> if_instr=32'h0B0A0908, if_pc=8 held; cycle after if_ready rises if_pc=12, no bubble.
REQ-031 redirect_valid=1, redirect_pc=40 while if_pc=16 -> next cycle if_valid=0, pc_addr=40; following cycle if_pc=40, if_instr=32'h2B2A2928.
REQ-032 Redirect to 32'h22 -> fault=1, if_valid=0 next cycle; later redirect to 8 ignored; reset clears fault and restarts at 0.
REQ-033 Assert reset=0 during STALL -> next cycle if_valid=0, pc_addr=RESET_PC; after release the held word is never presented.
